// File: rtl/pc_unit.sv
// Fetch program counter with prioritised next-PC select and a one-entry
// buffer that holds a redirect arriving during a stall until the stall releases.
module pc_unit #(
    parameter int unsigned   W           = 32,
    parameter logic [W-1:0]  RESET_VEC   = W'(32'h3000),
    parameter logic [W-1:0]  HANDLER_VEC = W'(32'h4180),
    parameter int unsigned   STEP        = 4,
    parameter logic [W-1:0]  IMEM_LO     = W'(32'h3000),
    parameter logic [W-1:0]  IMEM_HI     = W'(32'h6FFC)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         req,
    input  logic         eret,
    input  logic [W-1:0] epc,
    input  logic         br_valid,
    input  logic [W-1:0] br_target,
    output logic [W-1:0] pc,
    output logic         pend_valid,
    output logic         fetch_exc
);

    logic [W-1:0] pend_target;
    logic [W-1:0] pc_nxt;
    logic [W-1:0] pend_target_nxt;
    logic         pend_valid_nxt;

    // Next-state select: exception > eret > stall (buffer) > live redirect > buffered > step
    always_comb begin
        pc_nxt          = pc;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        if (req) begin
            pc_nxt         = HANDLER_VEC;
            pend_valid_nxt = 1'b0;
        end else if (eret) begin
            pc_nxt         = epc;
            pend_valid_nxt = 1'b0;
        end else if (stall) begin
            if (br_valid) begin
                pend_target_nxt = br_target;
                pend_valid_nxt  = 1'b1;
            end
        end else if (br_valid) begin
            pc_nxt         = br_target;
            pend_valid_nxt = 1'b0;
        end else if (pend_valid) begin
            pc_nxt         = pend_target;
            pend_valid_nxt = 1'b0;
        end else begin
            pc_nxt = pc + W'(STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_VEC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            pc          <= pc_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    // Address error is a pure function of the registered pc; it never gates updates
    assign fetch_exc = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: reset, stall buffering, priority
// between req/eret/redirects, address-range flags and wraparound.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic        br_valid;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        pend_valid;
    logic        fetch_exc;

    int checks;
    int failures;

    pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .req        (req),
        .eret       (eret),
        .epc        (epc),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .pc         (pc),
        .pend_valid (pend_valid),
        .fetch_exc  (fetch_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic e, input logic b,
                         input logic [31:0] ep, input logic [31:0] bt);
        stall     = s;
        req       = r;
        eret      = e;
        br_valid  = b;
        epc       = ep;
        br_target = bt;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3004;
        exp_pc[1] = 32'h3008;
        exp_pc[2] = 32'h300C;
        reset = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        checks++;
        if (pc !== 32'h3000) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000);
        end
        checks++;
        if (pend_valid !== 1'b0 || fetch_exc !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got pv=%b exc=%b exp pv=0 exc=0", pend_valid, fetch_exc);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc !== exp_pc[i] || fetch_exc !== 1'b0) begin
                failures++;
                $display("FAIL idle_step%0d got pc=%h exc=%b exp pc=%h exc=0", i, pc, fetch_exc, exp_pc[i]);
            end
        end
    endtask

    task automatic test_stall_pending();
        logic [1:0] bv;
        bv = 2'b00;
        for (int i = 0; i < 3; i++) begin
            bv[0] = (i == 1);
            drive(1, 0, 0, bv[0], 32'h0, 32'h3100);
            tick();
            checks++;
            if (pc !== 32'h300C || pend_valid !== (i >= 1)) begin
                failures++;
                $display("FAIL stall_hold%0d got pc=%h pv=%b exp pc=300c pv=%b", i, pc, pend_valid, (i >= 1));
            end
        end
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        #1;
        checks++;
        if (pc !== 32'h300C) begin
            failures++;
            $display("FAIL no_comb_path got=%h exp=%h", pc, 32'h300C);
        end
        tick();
        checks++;
        if (pc !== 32'h3100 || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL pend_apply got pc=%h pv=%b exp pc=3100 pv=0", pc, pend_valid);
        end
        tick();
        checks++;
        if (pc !== 32'h3104) begin
            failures++;
            $display("FAIL after_pend got=%h exp=%h", pc, 32'h3104);
        end
    endtask

    task automatic test_req_over_pending();
        drive(1, 0, 0, 1, 32'h0, 32'h3100);
        tick();
        checks++;
        if (pc !== 32'h3104 || pend_valid !== 1'b1) begin
            failures++;
            $display("FAIL req_setup got pc=%h pv=%b exp pc=3104 pv=1", pc, pend_valid);
        end
        drive(1, 1, 0, 0, 32'h0, 32'h0);
        tick();
        checks++;
        if (pc !== 32'h4180 || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL req_vector got pc=%h pv=%b exp pc=4180 pv=0", pc, pend_valid);
        end
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        checks++;
        if (pc !== 32'h4184) begin
            failures++;
            $display("FAIL req_next got=%h exp=%h", pc, 32'h4184);
        end
    endtask

    task automatic test_eret_priority();
        drive(0, 1, 1, 0, 32'h3024, 32'h0);
        tick();
        checks++;
        if (pc !== 32'h4180) begin
            failures++;
            $display("FAIL req_beats_eret got=%h exp=%h", pc, 32'h4180);
        end
        drive(1, 0, 1, 1, 32'h3024, 32'h5000);
        tick();
        checks++;
        if (pc !== 32'h3024 || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL eret got pc=%h pv=%b exp pc=3024 pv=0", pc, pend_valid);
        end
        drive(1, 0, 0, 1, 32'h0, 32'h3300);
        tick();
        checks++;
        if (pc !== 32'h3024 || pend_valid !== 1'b1) begin
            failures++;
            $display("FAIL eret_pend_setup got pc=%h pv=%b exp pc=3024 pv=1", pc, pend_valid);
        end
        drive(0, 0, 0, 1, 32'h0, 32'h3200);
        tick();
        checks++;
        if (pc !== 32'h3200 || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL live_beats_pend got pc=%h pv=%b exp pc=3200 pv=0", pc, pend_valid);
        end
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        checks++;
        if (pc !== 32'h3204) begin
            failures++;
            $display("FAIL pend_dropped got=%h exp=%h", pc, 32'h3204);
        end
    endtask

    task automatic test_fetch_exc();
        logic [31:0] tgt [5];
        logic        exc [5];
        tgt[0] = 32'h3002; exc[0] = 1'b1;
        tgt[1] = 32'h7000; exc[1] = 1'b1;
        tgt[2] = 32'h6FFC; exc[2] = 1'b0;
        tgt[3] = 32'h2FFC; exc[3] = 1'b1;
        tgt[4] = 32'h3000; exc[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 32'h0, tgt[i]);
            tick();
            checks++;
            if (pc !== tgt[i] || fetch_exc !== exc[i]) begin
                failures++;
                $display("FAIL exc_%0d got pc=%h exc=%b exp pc=%h exc=%b", i, pc, fetch_exc, tgt[i], exc[i]);
            end
        end
        drive(0, 0, 0, 1, 32'h0, 32'h6FFC);
        tick();
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        checks++;
        if (pc !== 32'h7000 || fetch_exc !== 1'b1) begin
            failures++;
            $display("FAIL exc_no_block got pc=%h exc=%b exp pc=7000 exc=1", pc, fetch_exc);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 0, 0, 1, 32'h0, 32'h3400);
        tick();
        checks++;
        if (pend_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_setup got pv=%b exp pv=1", pend_valid);
        end
        reset = 1'b1;
        drive(1, 1, 1, 1, 32'h5555, 32'h3500);
        tick();
        checks++;
        if (pc !== 32'h3000 || pend_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_stall got pc=%h pv=%b exp pc=3000 pv=0", pc, pend_valid);
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        checks++;
        if (pc !== 32'h3004) begin
            failures++;
            $display("FAIL rst_clears_pend got=%h exp=%h", pc, 32'h3004);
        end
        drive(0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0);
        tick();
        checks++;
        if (pc !== 32'hFFFF_FFFC || fetch_exc !== 1'b1) begin
            failures++;
            $display("FAIL eret_top got pc=%h exc=%b exp pc=fffffffc exc=1", pc, fetch_exc);
        end
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        tick();
        checks++;
        if (pc !== 32'h0 || fetch_exc !== 1'b1) begin
            failures++;
            $display("FAIL wrap got pc=%h exc=%b exp pc=00000000 exc=1", pc, fetch_exc);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 32'h0);
        test_reset();
        test_stall_pending();
        test_req_over_pending();
        test_eret_priority();
        test_fetch_exc();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
